mem_responder: RTL

- Memory-side responder for the datapath's MAR/MDR interface.
- Accepts read and write strobes from the CPU control path. On a read, returns the word at the latched address on `mdata_out`, which feeds the datapath's `MdataIn`. On a write, stores the MDR value.
- Models a word-addressed synchronous RAM with a configurable wait-state latency and a one-cycle completion strobe. The control FSM uses that strobe to advance out of its memory states.

---
 rtl/mem_responder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Word-addressed RAM behind the MAR/MDR interface: edge-triggered strobes, RD_LAT/WR_LAT wait states, one-cycle mem_ready.
// Define MEM_ADDR_CHECK_EN to build the sticky out-of-range flag on addr_err; otherwise addr_err is tied low.
module mem_responder #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] mdata_out,
    output logic              mem_ready,
    output logic              busy,
    output logic              addr_err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_WR_WAIT = 2'd2;

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      RD_CNT  = 4'(RD_LAT - 1);
    localparam logic [3:0]      WR_CNT  = 4'(WR_LAT - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] mdata_q, mdata_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              rd_prev_q, rd_prev_d;
    logic              wr_prev_q, wr_prev_d;

    logic              rd_edge, wr_edge;
    logic              in_range;
    logic              mem_we;
    logic [DATA_W-1:0] rd_word;

    assign rd_edge  = read & ~rd_prev_q;
    assign wr_edge  = write & ~wr_prev_q;
    assign in_range = ({1'b0, addr_q} < DEPTH_L);
    assign rd_word  = in_range ? mem[addr_q[IDX_W-1:0]] : '0;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mdata_d   = mdata_q;
        ready_d   = 1'b0;
        busy_d    = busy_q;
        mem_we    = 1'b0;
        // History tracks the strobes every cycle so edges seen while busy are consumed, not deferred.
        rd_prev_d = read;
        wr_prev_d = write;
        case (state_q)
            ST_IDLE: begin
                if (wr_edge) begin
                    addr_d  = address;
                    wdata_d = data_in;
                    cnt_d   = WR_CNT;
                    busy_d  = 1'b1;
                    state_d = ST_WR_WAIT;
                end else if (rd_edge) begin
                    addr_d  = address;
                    cnt_d   = RD_CNT;
                    busy_d  = 1'b1;
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    mdata_d = rd_word;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_WR_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    mem_we  = in_range;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        // A clear on the completion edge aborts the write.
        if (clr) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mdata_q   <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            rd_prev_q <= 1'b0;
            wr_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mdata_q   <= mdata_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            rd_prev_q <= rd_prev_d;
            wr_prev_q <= wr_prev_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q[IDX_W-1:0]] <= wdata_q;
        end
    end

    assign mdata_out = mdata_q;
    assign mem_ready = ready_q;
    assign busy      = busy_q;

`ifdef MEM_ADDR_CHECK_EN
    logic addr_err_q, addr_err_d;

    always_comb begin
        addr_err_d = addr_err_q;
        if ((state_q == ST_IDLE) && (wr_edge || rd_edge) && ({1'b0, address} >= DEPTH_L)) begin
            addr_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= addr_err_d;
        end
    end

    assign addr_err = addr_err_q;
`else
    assign addr_err = 1'b0;
`endif

endmodule
